// File: rtl/rgb_timing_gen.sv
// Video timing generator with a registered RGB pixel source.
// Optional colour bars are enabled with `define RGB_TIMING_GEN_BARS_EN; the default build emits an h/v ramp.
module rgb_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       rgb_out_vsync,
  output logic       rgb_out_hsync,
  output logic       rgb_out_de,
  output logic [7:0] rgb_out_data_r,
  output logic [7:0] rgb_out_data_g,
  output logic [7:0] rgb_out_data_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;

  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  data_r_q, data_r_d;
  logic [7:0]  data_g_q, data_g_d;
  logic [7:0]  data_b_q, data_b_d;

  logic        h_wrap;
  logic        de_now;
  logic        hs_now;
  logic        vs_now;
  logic [23:0] pixel_rgb;

  assign h_wrap = (h_cnt_q == H_LAST);

  // Raster counters; the vertical counter steps only when the line wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_wrap) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

`ifdef RGB_TIMING_GEN_BARS_EN
  // Bar width is H_ACTIVE/8; the last bar absorbs any remainder pixels.
  localparam int          BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] bar_pix_q, bar_pix_d;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    if (enable) begin
      if (h_wrap) begin
        bar_idx_d = 3'd0;
        bar_pix_d = 12'd0;
      end else if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = 12'd0;
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
        end
      end else begin
        bar_pix_d = bar_pix_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_idx_q <= 3'd0;
      bar_pix_q <= 12'd0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
    end
  end

  assign pixel_rgb = bar_colour(bar_idx_q);
`else
  assign pixel_rgb = {h_cnt_q[7:0], v_cnt_q[7:0], 8'h00};
`endif

  assign de_now = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign hs_now = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_now = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

  // Outputs decode this cycle's position; a frozen generator shows a blank, sync-idle raster.
  always_comb begin
    de_d          = 1'b0;
    frame_start_d = 1'b0;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    data_r_d      = 8'h00;
    data_g_d      = 8'h00;
    data_b_d      = 8'h00;
    if (enable) begin
      de_d          = de_now;
      frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
      hsync_d       = hs_now ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = vs_now ? VSYNC_POL : ~VSYNC_POL;
      if (de_now) begin
        data_r_d = pixel_rgb[23:16];
        data_g_d = pixel_rgb[15:8];
        data_b_d = pixel_rgb[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      data_r_q      <= 8'h00;
      data_g_q      <= 8'h00;
      data_b_q      <= 8'h00;
    end else begin
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      data_r_q      <= data_r_d;
      data_g_q      <= data_g_d;
      data_b_q      <= data_b_d;
    end
  end

  assign rgb_out_de     = de_q;
  assign rgb_out_hsync  = hsync_q;
  assign rgb_out_vsync  = vsync_q;
  assign frame_start    = frame_start_q;
  assign rgb_out_data_r = data_r_q;
  assign rgb_out_data_g = data_g_q;
  assign rgb_out_data_b = data_b_q;

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Directed bench for rgb_timing_gen on a 24x12 raster (16x8 active); checks ramp or bars per build.
module tb_rgb_timing_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       vsync, hsync, de, fs;
  logic [7:0] r, g, b;
  logic       vsync18, hsync18, de18, fs18;
  logic [7:0] r18, g18, b18;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rgb_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rgb_out_vsync(vsync), .rgb_out_hsync(hsync), .rgb_out_de(de),
    .rgb_out_data_r(r), .rgb_out_data_g(g), .rgb_out_data_b(b),
    .frame_start(fs)
  );

  rgb_timing_gen #(
    .H_ACTIVE(18), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut18 (
    .clk(clk), .reset(reset), .enable(enable),
    .rgb_out_vsync(vsync18), .rgb_out_hsync(hsync18), .rgb_out_de(de18),
    .rgb_out_data_r(r18), .rgb_out_data_g(g18), .rgb_out_data_b(b18),
    .frame_start(fs18)
  );

  // {de, hsync, vsync, frame_start, r, g, b}
  function automatic logic [27:0] snap();
    return {de, hsync, vsync, fs, r, g, b};
  endfunction

  function automatic logic [27:0] pk(input logic d, input logic hs, input logic vs,
                                     input logic f, input logic [23:0] rgb);
    return {d, hs, vs, f, rgb};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds reset for two cycles, checks reset outputs, releases with enable=1 at a negedge.
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    run(2);
    check("reset_state", 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    check("reset_state18", 32'({de18, hsync18, vsync18, fs18, r18, g18, b18}),
          32'(pk(0, 1, 1, 0, 24'h0)));
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          k;
    logic [27:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] rec[0:300];
  logic [24:0] rec18[0:300];
  logic [24:0] exp_q[$];

  function automatic logic [23:0] col(input logic [23:0] ramp, input logic [23:0] bars);
`ifdef RGB_TIMING_GEN_BARS_EN
    return bars;
`else
    return ramp;
`endif
  endfunction

  initial begin
    int          cnt;
    logic [24:0] e18;
    reset  = 1'b1;
    enable = 1'b0;

    // Output sample k (after k edges from release) shows position p = k-1, h = p%24, v = p/24.
    vecs.push_back('{1,   pk(1, 1, 1, 1, col(24'h000000, 24'hFFFFFF))});
    vecs.push_back('{2,   pk(1, 1, 1, 0, col(24'h010000, 24'hFFFFFF))});
    vecs.push_back('{6,   pk(1, 1, 1, 0, col(24'h050000, 24'h00FFFF))});
    vecs.push_back('{15,  pk(1, 1, 1, 0, col(24'h0E0000, 24'h000000))});
    vecs.push_back('{16,  pk(1, 1, 1, 0, col(24'h0F0000, 24'h000000))});
    vecs.push_back('{17,  pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{18,  pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{19,  pk(0, 0, 1, 0, 24'h0)});
    vecs.push_back('{22,  pk(0, 0, 1, 0, 24'h0)});
    vecs.push_back('{23,  pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{78,  pk(1, 1, 1, 0, col(24'h050300, 24'h00FFFF))});
    vecs.push_back('{184, pk(1, 1, 1, 0, col(24'h0F0700, 24'h000000))});
    vecs.push_back('{193, pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{216, pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{217, pk(0, 1, 0, 0, 24'h0)});
    vecs.push_back('{236, pk(0, 0, 0, 0, 24'h0)});
    vecs.push_back('{264, pk(0, 1, 0, 0, 24'h0)});
    vecs.push_back('{265, pk(0, 1, 1, 0, 24'h0)});
    vecs.push_back('{289, pk(1, 1, 1, 1, col(24'h000000, 24'hFFFFFF))});

    // H_ACTIVE=18 instance: pixels 13..18 of line 0, as {de, rgb}
    exp_q.push_back({1'b1, col(24'h0D0000, 24'h0000FF)});
    exp_q.push_back({1'b1, col(24'h0E0000, 24'h000000)});
    exp_q.push_back({1'b1, col(24'h0F0000, 24'h000000)});
    exp_q.push_back({1'b1, col(24'h100000, 24'h000000)});
    exp_q.push_back({1'b1, col(24'h110000, 24'h000000)});
    exp_q.push_back({1'b0, 24'h000000});

    // ---- free-running frame ----
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      cycle();
      rec[k]   = snap();
      rec18[k] = {de18, r18, g18, b18};
    end
    foreach (vecs[i]) begin
      check($sformatf("vec_k%0d", vecs[i].k), 32'(rec[vecs[i].k]), 32'(vecs[i].exp));
    end
    for (int k = 14; k <= 19; k++) begin
      e18 = exp_q.pop_front();
      check($sformatf("h18_pix%0d", k - 1), 32'(rec18[k]), 32'(e18));
    end
    for (int v = 0; v < 12; v++) begin
      cnt = 0;
      for (int h = 1; h <= 24; h++) cnt += int'(rec[v * 24 + h][27]);
      check($sformatf("de_per_line_v%0d", v), 32'(cnt), (v < 8) ? 32'd16 : 32'd0);
    end
    cnt = 0;
    for (int k = 1; k <= 288; k++) cnt += int'(rec[k][24]);
    check("fs_per_frame", 32'(cnt), 32'd1);

    // ---- freeze at h=5,v=2 ----
    do_reset();
    run(53);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("freeze_%0d", i), 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    end
    enable = 1'b1;
    cycle();
    check("resume_h5v2", 32'(snap()), 32'(pk(1, 1, 1, 0, col(24'h050200, 24'h00FFFF))));
    cycle();
    check("resume_h6v2", 32'(snap()), 32'(pk(1, 1, 1, 0, col(24'h060200, 24'h00FF00))));

    // ---- reset mid-frame at h=10,v=4 ----
    do_reset();
    run(106);
    check("pre_reset_de", 32'(de), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset", 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    @(negedge clk);
    run(2);
    check("held_reset", 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    reset = 1'b0;
    cycle();
    check("post_reset_fs", 32'(snap()), 32'(pk(1, 1, 1, 1, col(24'h000000, 24'hFFFFFF))));
    cycle();
    check("post_reset_h1", 32'(snap()), 32'(pk(1, 1, 1, 0, col(24'h010000, 24'hFFFFFF))));

    // ---- enable dropped on the frame wrap cycle ----
    do_reset();
    run(287);
    check("wrap_pre", 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      cnt += int'(fs);
      check($sformatf("wrap_frozen_%0d", i), 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    end
    enable = 1'b1;
    cycle();
    cnt += int'(fs);
    check("wrap_h23v11", 32'(snap()), 32'(pk(0, 1, 1, 0, 24'h0)));
    cycle();
    cnt += int'(fs);
    check("wrap_new_frame", 32'(snap()), 32'(pk(1, 1, 1, 1, col(24'h000000, 24'hFFFFFF))));
    for (int i = 0; i < 40; i++) begin
      cycle();
      cnt += int'(fs);
    end
    check("wrap_fs_once", 32'(cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_timing_gen.md
RGB_TIMING_GEN -- requirements
Module: rgb_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, same meanings in lines.
REQ-006 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-007 SHALL have port clk  input  1  pixel clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  run/freeze control.
REQ-010 SHALL have ports rgb_out_vsync / rgb_out_hsync / rgb_out_de  output  1 each  video timing, feeding the rgb_in_* stage downstream.
REQ-011 SHALL have ports rgb_out_data_r / _g / _b  output  8 each  pixel colour.
REQ-012 SHALL have port frame_start  output  1  single-cycle start-of-frame pulse.

Function
REQ-013 SHALL keep h_cnt in 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, 12 bits wide; increment when enable=1, wrap to 0 after H_TOTAL-1.
REQ-014 SHALL keep v_cnt in 0..V_TOTAL-1, 12 bits; increment only on h_cnt wrap; wrap to 0 after V_TOTAL-1 at the same edge h_cnt wraps.
REQ-015 SHALL register all outputs; outputs in cycle n+1 decode (h_cnt, v_cnt) of cycle n (latency 1).
REQ-016 SHALL assert hsync (level HSYNC_POL) iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-017 SHALL assert vsync (level VSYNC_POL) iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; vsync edges coincide with h_cnt=0.
REQ-018 SHALL assert de iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-019 SHALL pulse frame_start for exactly one cycle, coincident with de of pixel (0,0).
REQ-020 SHALL drive data_r/g/b = 0 whenever de = 0.
REQ-021 SHALL, when enable=0, freeze h_cnt/v_cnt, force de=0, frame_start=0, syncs inactive, data 0, from the next cycle.
REQ-022 SHALL, when enable returns to 1, resume counting from the frozen position without re-starting the frame.
REQ-023 SHALL derive bar position with a per-line bar counter (no divider): bar width W = H_ACTIVE/8 (integer); bar k covers h_cnt k*W..k*W+W-1; remainder pixels belong to bar 7.

Reset
REQ-024 SHALL, while reset=1, hold h_cnt=0, v_cnt=0, bar counter=0, de=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, data=0.
REQ-025 SHALL, on reset mid-frame, abandon the frame; first edge with reset=0 and enable=1 starts a new frame at (0,0).

Configuration
REQ-026 SHALL use macro RGB_TIMING_GEN_BARS_EN.
REQ-027 SHALL, with RGB_TIMING_GEN_BARS_EN defined, output colour bars 0..7 = white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000 (r,g,b).
REQ-028 SHALL, without the macro, output ramp r=h_cnt[7:0], g=v_cnt[7:0], b=0 during de; bar counter not instantiated.

Verification (params H 16/2/4/2, V 8/1/2/1, H_TOTAL=24, V_TOTAL=12)
REQ-029 SHALL check: reset released, enable=1 -> frame_start at cycle 1, de high 16 cycles per line, 8 lines, period 288 cycles.
REQ-030 SHALL check: hsync low for cycles h=18..21 of every line; vsync low for lines 9..10, edges aligned to h=0.
REQ-031 SHALL check: bars enabled, W=2 -> pixel 0,1 = FFFFFF, pixel 14,15 = 000000; H_ACTIVE=18 -> pixels 14..17 black; without macro, line 3 pixel 5 = (05,03,00).
REQ-032 SHALL check: enable=0 at h=5,v=2 for 10 cycles -> de=0, syncs inactive; on re-enable next de pixel is h=5,v=2 (ramp 05,02,00).
REQ-033 SHALL check: reset asserted at h=10,v=4 -> all outputs at reset values immediately; after release next frame_start one cycle later, no partial frame.
REQ-034 SHALL check: enable toggled on the h_cnt=23,v_cnt=11 wrap cycle -> wrap deferred until next enabled cycle, frame_start once only.
